// File: rtl/ram_dist_nxw_dp.sv
// DEPTH x WIDTH simple-dual-port distributed RAM: one write port, an asynchronous
// read port O, a registered read-first port Q, and a sweep engine restoring INIT.
module ram_dist_nxw_dp #(
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter logic [DEPTH*WIDTH-1:0] INIT = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] RA,
  output logic [WIDTH-1:0]  O,
  input  logic              RE,
  output logic [WIDTH-1:0]  Q,
  input  logic              CLR,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef logic [WIDTH-1:0] mem_t [DEPTH];
  typedef enum logic { IDLE, SWEEP } state_t;

  function automatic mem_t init_image();
    mem_t img;
    for (int n = 0; n < DEPTH; n++) img[n] = INIT[n*WIDTH +: WIDTH];
    return img;
  endfunction

  mem_t              mem   = init_image();
  state_t            state = IDLE;
  state_t            state_d;
  logic [ADDR_W-1:0] cnt   = '0;
  logic [ADDR_W-1:0] cnt_d;
  logic              done_q = 1'b0;
  logic              done_d;
  logic              sweep_we;
  logic [WIDTH-1:0]  q_r   = '0;

  // Re-init handshake: CLR (pulse or level) is accepted only in IDLE; BUSY stays
  // high for DEPTH cycles while user writes are dropped, then DONE pulses once.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    done_d   = 1'b0;
    sweep_we = 1'b0;
    case (state)
      IDLE: begin
        if (CLR) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        sweep_we = 1'b1;
        cnt_d    = cnt + 1'b1;
        if (cnt == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      done_q <= done_d;
    end
  end

  // Reset leaves memory untouched but blocks both the sweep and user writes.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (sweep_we)
        mem[cnt] <= INIT[int'(cnt)*WIDTH +: WIDTH];
      else if (WE && !CLR && state == IDLE)
        mem[WA] <= D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      q_r <= '0;
    else if (RE)
      q_r <= mem[RA];
  end

  assign O    = mem[RA];
  assign Q    = q_r;
  assign BUSY = (state == SWEEP);
  assign DONE = done_q;

endmodule

// File: tb/tb_ram_dist_nxw_dp.sv
// Directed bench for ram_dist_nxw_dp with WIDTH=8, DEPTH=16 and INIT word n = n+1.
module tb_ram_dist_nxw_dp;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam logic [DEPTH*WIDTH-1:0] TB_INIT = 128'h100F0E0D0C0B0A090807060504030201;

  logic              CLK = 1'b0;
  logic              RST, WE, RE, CLR;
  logic [ADDR_W-1:0] WA, RA;
  logic [WIDTH-1:0]  D;
  logic [WIDTH-1:0]  O, Q;
  logic              BUSY, DONE;

  int n_checks = 0;
  int n_errors = 0;

  ram_dist_nxw_dp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(TB_INIT)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .WA(WA), .D(D), .RA(RA), .O(O),
    .RE(RE), .Q(Q), .CLR(CLR), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic read_o(input int a, input logic [WIDTH-1:0] exp, input string tag);
    RA = ADDR_W'(a);
    #1;
    check(tag, 32'(O), 32'(exp));
  endtask

  // Counts edges after the CLR edge until DONE appears (bounded).
  task automatic wait_done(inout int edges);
    while (!DONE && edges < 40) begin
      step();
      edges++;
    end
  endtask

  initial begin
    int edges;
    int dones;
    RST = 0; WE = 0; RE = 0; CLR = 0; WA = '0; RA = '0; D = '0;
    #1;
    // Power-up state
    check("pwr_q", 32'(Q), 0);
    check("pwr_busy", 32'(BUSY), 0);
    check("pwr_done", 32'(DONE), 0);
    read_o(5, 8'h06, "pwr_o5");
    RE = 1;
    step();
    RE = 0;
    check("pwr_q5", 32'(Q), 32'h06);

    // Read-first registered port vs write
    WE = 1; WA = 4'd3; D = 8'hA5; RA = 4'd3; RE = 1;
    step();
    WE = 0; RE = 0;
    check("rf_q_old", 32'(Q), 32'h04);
    check("rf_o_new", 32'(O), 32'hA5);

    // Fill, then full sweep
    for (int i = 0; i < DEPTH; i++) begin
      WE = 1; WA = ADDR_W'(i); D = 8'hC0 + 8'(i);
      step();
    end
    WE = 0;
    read_o(7, 8'hC7, "fill_o7");
    CLR = 1;
    step();
    CLR = 0;
    check("sw_busy0", 32'(BUSY), 1);
    edges = 0;
    wait_done(edges);
    check("sw_len", 32'(edges), 16);
    check("sw_busy_at_done", 32'(BUSY), 0);
    step();
    check("sw_done_len", 32'(DONE), 0);
    for (int i = 0; i < DEPTH; i++) read_o(i, 8'(i + 1), "sw_init");

    // Writes dropped while busy; CLR mid-sweep ignored
    CLR = 1;
    step();
    CLR = 0;
    edges = 0;
    while (!DONE && edges < 40) begin
      step();
      edges++;
      if (edges == 3) begin WE = 1; WA = 4'd2; D = 8'hFF; CLR = 1; end
      if (edges == 5) CLR = 0;
    end
    WE = 0; CLR = 0;
    check("busy_len", 32'(edges), 16);
    read_o(2, 8'h03, "busy_we_drop");

    // Abort a sweep with RST after 5 sweep edges
    RE = 1; RA = 4'd9;
    for (int i = 0; i < DEPTH; i++) begin
      WE = 1; WA = ADDR_W'(i); D = 8'h55;
      step();
    end
    WE = 0;
    step();
    check("abort_q_pre", 32'(Q), 32'h55);
    CLR = 1;
    step();
    CLR = 0;
    for (int i = 0; i < 5; i++) step();
    RST = 1;
    step();
    RST = 0; RE = 0;
    check("abort_busy", 32'(BUSY), 0);
    check("abort_done", 32'(DONE), 0);
    check("abort_q", 32'(Q), 0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (DONE) dones++;
    end
    check("abort_no_done", 32'(dones), 0);
    for (int i = 0; i < DEPTH; i++)
      read_o(i, (i < 5) ? 8'(i + 1) : 8'h55, "abort_mem");

    // RST wins over CLR; WE with CLR in IDLE is dropped
    RST = 1; CLR = 1;
    step();
    RST = 0; CLR = 0;
    check("rst_clr_busy", 32'(BUSY), 0);
    step();
    check("rst_clr_busy2", 32'(BUSY), 0);
    WE = 1; WA = 4'd6; D = 8'h77; CLR = 1;
    step();
    WE = 0; CLR = 0;
    check("we_clr_busy", 32'(BUSY), 1);
    read_o(6, 8'h55, "we_clr_drop");
    edges = 0;
    wait_done(edges);
    check("we_clr_len", 32'(edges), 16);
    read_o(6, 8'h07, "we_clr_init6");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
